// File: rtl/synaptic_update_engine.sv
// Sweeps LEN words of weight/gradient memory and applies a spike-count learning rule. Latency is 3 cycles per word plus 1.
// There is no backpressure: START is dropped while BUSY, and host reads are honoured only in IDLE.
module synaptic_update_engine #(
  parameter int LANES        = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int GRAD_WIDTH   = 8,
  parameter int CNT_WIDTH    = 7,
  parameter int ADDR_WIDTH   = 16,
  parameter int LR_SHIFT     = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          START,
  input  logic                          MODE,
  input  logic                          IS_POS,
  input  logic                          IS_TRAIN,
  input  logic [ADDR_WIDTH-1:0]         BASE_ADDR,
  input  logic [ADDR_WIDTH-1:0]         LEN,
  input  logic [CNT_WIDTH-1:0]          PRE_S_CNT,
  output logic                          POST_RD_EN,
  output logic [ADDR_WIDTH-1:0]         POST_WORD_ADDR,
  input  logic [LANES*CNT_WIDTH-1:0]    POST_S_CNT,
  input  logic                          HOST_RD_EN,
  input  logic [ADDR_WIDTH-1:0]         HOST_ADDR,
  output logic [LANES*WEIGHT_WIDTH-1:0] HOST_RDATA,
  output logic                          BUSY,
  output logic                          DONE
);

  localparam int WORD_W  = LANES * WEIGHT_WIDTH;
  localparam int GWORD_W = LANES * GRAD_WIDTH;
  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int XW      = 2 * CNT_WIDTH + GRAD_WIDTH;
  localparam int SW      = ((WEIGHT_WIDTH > GRAD_WIDTH) ? WEIGHT_WIDTH : GRAD_WIDTH) + 2;

  localparam logic [XW-1:0]        D_MAX = XW'((1 << (GRAD_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] G_HI  = SW'((1 << (GRAD_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] G_LO  = ~G_HI;
  localparam logic signed [SW-1:0] W_HI  = SW'((1 << (WEIGHT_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] W_LO  = ~W_HI;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_FIN} state_t;

  state_t                 state_q, state_d;
  logic                   mode_q, is_pos_q;
  logic [ADDR_WIDTH-1:0]  base_q, len_q, cnt_q;
  logic [CNT_WIDTH-1:0]   pre_q;
  logic [WORD_W-1:0]      new_w, new_w_q, w_rd_q, host_hold_q;
  logic [GWORD_W-1:0]     new_g, new_g_q, g_rd_q;
  logic                   host_vld_q;

  logic                   start_acc, host_rd, w_ce, g_ce, mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;

  logic [CNT_WIDTH-1:0]    lane_post;
  logic [XW-1:0]           prod;
  logic [GRAD_WIDTH-1:0]   mag;
  logic signed [SW-1:0]    delta, g_ext, w_ext, g_sum, w_sum;
  logic [GRAD_WIDTH-1:0]   g_sat;
  logic [WEIGHT_WIDTH-1:0] w_sat;

  assign start_acc = (state_q == S_IDLE) && START && IS_TRAIN;
  assign host_rd   = (state_q == S_IDLE) && HOST_RD_EN && !start_acc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc)
                 state_d = ((LEN == '0) || (!MODE && (PRE_S_CNT == '0))) ? S_FIN : S_READ;
      S_READ:  state_d = S_CALC;
      S_CALC:  state_d = S_WRITE;
      S_WRITE: state_d = (cnt_q == len_q - ADDR_WIDTH'(1)) ? S_FIN : S_READ;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      is_pos_q    <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
      new_w_q     <= '0;
      new_g_q     <= '0;
      host_vld_q  <= 1'b0;
      host_hold_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        mode_q   <= MODE;
        is_pos_q <= IS_POS;
        base_q   <= BASE_ADDR;
        len_q    <= LEN;
        pre_q    <= PRE_S_CNT;
        cnt_q    <= '0;
      end else if (state_q == S_WRITE) begin
        cnt_q <= cnt_q + ADDR_WIDTH'(1);
      end
      if (state_q == S_CALC) begin
        new_w_q <= new_w;
        new_g_q <= new_g;
      end
      host_vld_q <= host_rd;
      // Freeze the host word so later sweep reads cannot disturb HOST_RDATA.
      if (host_vld_q) host_hold_q <= w_rd_q;
    end
  end

  assign BUSY           = (state_q != S_IDLE);
  assign DONE           = (state_q == S_FIN);
  assign POST_RD_EN     = (state_q == S_READ);
  assign POST_WORD_ADDR = cnt_q;
  assign HOST_RDATA     = host_vld_q ? w_rd_q : host_hold_q;

  assign mem_we   = (state_q == S_WRITE);
  assign g_ce     = (state_q == S_READ) || mem_we;
  assign w_ce     = g_ce || host_rd;
  assign mem_addr = (state_q == S_IDLE) ? HOST_ADDR : (base_q + cnt_q);

  logic [WORD_W-1:0]  weight_mem [DEPTH];
  logic [GWORD_W-1:0] grad_mem   [DEPTH];

  always_ff @(posedge CLK) begin
    if (w_ce) begin
      if (mem_we) weight_mem[mem_addr] <= new_w_q;
      else        w_rd_q               <= weight_mem[mem_addr];
    end
    if (g_ce) begin
      if (mem_we) grad_mem[mem_addr] <= new_g_q;
      else        g_rd_q             <= grad_mem[mem_addr];
    end
  end

  always_comb begin
    new_w     = '0;
    new_g     = '0;
    lane_post = '0;
    prod      = '0;
    mag       = '0;
    delta     = '0;
    g_ext     = '0;
    w_ext     = '0;
    g_sum     = '0;
    w_sum     = '0;
    g_sat     = '0;
    w_sat     = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_post = POST_S_CNT[i*CNT_WIDTH +: CNT_WIDTH];
      prod      = XW'(pre_q) * XW'(lane_post);
      mag       = (prod > D_MAX) ? D_MAX[GRAD_WIDTH-1:0] : prod[GRAD_WIDTH-1:0];
      delta     = SW'(mag);
      if (!is_pos_q) delta = -delta;
      g_ext = SW'($signed(g_rd_q[i*GRAD_WIDTH +: GRAD_WIDTH]));
      w_ext = SW'($signed(w_rd_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
      g_sum = g_ext + delta;
      w_sum = w_ext + (g_ext >>> LR_SHIFT);

      if (g_sum > G_HI)      g_sat = G_HI[GRAD_WIDTH-1:0];
      else if (g_sum < G_LO) g_sat = G_LO[GRAD_WIDTH-1:0];
      else                   g_sat = g_sum[GRAD_WIDTH-1:0];

      if (w_sum > W_HI)      w_sat = W_HI[WEIGHT_WIDTH-1:0];
      else if (w_sum < W_LO) w_sat = W_LO[WEIGHT_WIDTH-1:0];
      else                   w_sat = w_sum[WEIGHT_WIDTH-1:0];

      new_w[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = mode_q ? w_sat : w_rd_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      new_g[i*GRAD_WIDTH +: GRAD_WIDTH]     = mode_q ? '0 : g_sat;
    end
  end

endmodule
